// File: rtl/smc_int_pkg.sv
// smc_int_pkg: shared lane widths, clamp limits and per-beat control type for the SMC integer datapath
package smc_int_pkg;
  localparam int LANES_DEFAULT = 32;
  localparam int NIB_W = 4;
  localparam int LANE_W = 8;
  localparam int EXT_W = 10;
  localparam logic signed [EXT_W-1:0] S4_MAX = 10'sd7;
  localparam logic signed [EXT_W-1:0] S4_MIN = -10'sd8;
  localparam logic signed [EXT_W-1:0] U4_MAX = 10'sd15;
  localparam logic [2:0] MAX_SHIFT = 3'd4;
  typedef struct packed {
    logic [2:0] shift;
    logic       sign_i;
    logic       sign_o;
  } ctrl_t;
endpackage

// File: rtl/narrow8to4_lane.sv
// narrow8to4_lane: one lane's extend/shift (front half) and nibble clamp (back half); NARROW_ROUND_EN adds round-half-up before the shift
module narrow8to4_lane
  import smc_int_pkg::*;
(
  input  logic [LANE_W-1:0] i_v,
  input  logic [2:0]        i_shift,
  input  logic              i_sign_i,
  output logic [EXT_W-1:0]  o_r,
  input  logic [EXT_W-1:0]  i_r,
  input  logic              i_sign_o,
  output logic [NIB_W-1:0]  o_nib,
  output logic              o_sat
);
  logic [2:0] w_sh;
  logic signed [EXT_W-1:0] w_ext, w_pre, w_r, w_clamp;
  assign w_sh = (i_shift > MAX_SHIFT) ? MAX_SHIFT : i_shift;
  assign w_ext = i_sign_i ? {{(EXT_W-LANE_W){i_v[LANE_W-1]}}, i_v} : {{(EXT_W-LANE_W){1'b0}}, i_v};
`ifdef NARROW_ROUND_EN
  // 10 bits leave headroom for +8 on 255, so the rounding add cannot wrap
  assign w_pre = (w_sh == 3'd0) ? w_ext : w_ext + (EXT_W'(1) << (w_sh - 3'd1));
`else
  assign w_pre = w_ext;
`endif
  assign o_r = w_pre >>> w_sh;
  assign w_r = i_r;
  assign w_clamp = i_sign_o ? ((w_r > S4_MAX) ? S4_MAX : (w_r < S4_MIN) ? S4_MIN : w_r)
                            : (w_r[EXT_W-1] ? '0 : (w_r > U4_MAX) ? U4_MAX : w_r);
  assign o_sat = (w_clamp != w_r);
  assign o_nib = w_clamp[NIB_W-1:0];
endmodule

// File: rtl/narrow8to4.sv
// narrow8to4: requantize packed 8-bit lanes to 4-bit nibbles through a two-stage valid/ready pipeline with a saturation event counter
module narrow8to4
  import smc_int_pkg::*;
#(
  parameter int LANES = LANES_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*NIB_W-1:0] in_lo,
  input  logic [LANES*NIB_W-1:0] in_hi,
  input  logic [2:0]             in_shift,
  input  logic                   in_sign_i,
  input  logic                   in_sign_o,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*NIB_W-1:0] out_dst,
  output logic [LANES-1:0]       out_sat,
  input  logic                   clr_cnt,
  output logic [CNT_W-1:0]       sat_cnt
);
  ctrl_t w_ctrl;
  logic w_s2_load, w_s1_adv, w_in_fire;
  logic [LANES*EXT_W-1:0] w_r;
  logic [LANES*NIB_W-1:0] w_nib;
  logic [LANES-1:0] w_sat;
  logic r_s1_valid, r_s1_sign_o, r_s2_valid;
  logic [LANES*EXT_W-1:0] r_s1_r;
  logic [LANES*NIB_W-1:0] r_dst;
  logic [LANES-1:0] r_sat;
  logic [CNT_W-1:0] r_cnt;
  assign w_ctrl = '{shift: in_shift, sign_i: in_sign_i, sign_o: in_sign_o};
  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_adv = r_s1_valid && w_s2_load;
  assign in_ready = !r_s1_valid || w_s1_adv;
  assign w_in_fire = in_valid && in_ready;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    narrow8to4_lane u_lane (
      .i_v      ({in_hi[NIB_W*i+:NIB_W], in_lo[NIB_W*i+:NIB_W]}),
      .i_shift  (w_ctrl.shift),
      .i_sign_i (w_ctrl.sign_i),
      .o_r      (w_r[EXT_W*i+:EXT_W]),
      .i_r      (r_s1_r[EXT_W*i+:EXT_W]),
      .i_sign_o (r_s1_sign_o),
      .o_nib    (w_nib[NIB_W*i+:NIB_W]),
      .o_sat    (w_sat[i])
    );
  end
  // stage 1: capture shifted lane values and the output-sign flag that travels with the beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign_o <= 1'b0;
      r_s1_r <= '0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (w_in_fire) begin
        r_s1_sign_o <= w_ctrl.sign_o;
        r_s1_r <= w_r;
      end
    end
  end
  // stage 2: capture clamped nibbles and flags; held steady while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_dst <= '0;
      r_sat <= '0;
    end else begin
      if (w_s2_load) r_s2_valid <= r_s1_valid;
      if (w_s1_adv) begin
        r_dst <= w_nib;
        r_sat <= w_sat;
      end
    end
  end
  // count delivered beats with any clamp, sticking at all-ones; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (clr_cnt) r_cnt <= '0;
    else if (r_s2_valid && out_ready && |r_sat && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end
  assign out_valid = r_s2_valid;
  assign out_dst = r_dst;
  assign out_sat = r_sat;
  assign sat_cnt = r_cnt;
endmodule

// File: tb/tb_narrow8to4.sv
// tb_narrow8to4: directed vectors with hand-computed results for narrow8to4
module tb_narrow8to4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1, clr_cnt = 1'b0;
  logic in_sign_i = 1'b0, in_sign_o = 1'b0;
  logic [2:0] in_shift = 3'd0;
  logic [127:0] in_lo = '0, in_hi = '0;
  logic in_ready, out_valid;
  logic [127:0] out_dst;
  logic [31:0] out_sat;
  logic [15:0] sat_cnt;
  int total = 0, bad = 0;
  logic [15:0] exp_cnt = '0;

  narrow8to4 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_lo(in_lo), .in_hi(in_hi), .in_shift(in_shift), .in_sign_i(in_sign_i),
    .in_sign_o(in_sign_o), .out_valid(out_valid), .out_ready(out_ready),
    .out_dst(out_dst), .out_sat(out_sat), .clr_cnt(clr_cnt), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [127:0] lo, input logic [127:0] hi, input logic [2:0] sh, input logic si, input logic so);
    in_lo = lo; in_hi = hi; in_shift = sh; in_sign_i = si; in_sign_o = so; in_valid = 1'b1;
  endtask

  task automatic beat(input string tag, input logic [127:0] lo, input logic [127:0] hi, input logic [2:0] sh,
                      input logic si, input logic so, input logic [127:0] e_dst, input logic [31:0] e_sat);
    drive(lo, hi, sh, si, so);
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_dst"}, out_dst, e_dst);
    chk({tag, "_sat"}, out_sat, e_sat);
    if (e_sat != 0 && exp_cnt != '1) exp_cnt++;
    tick();
    chk({tag, "_cnt"}, sat_cnt, exp_cnt);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_dst", out_dst, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_cnt", sat_cnt, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", in_ready, 1);
    beat("s7_127", 128'hF7, 128'h70, 3'd0, 1'b1, 1'b1, 128'h77, 32'h2);
    beat("neg128", 128'h0, 128'h8, 3'd0, 1'b1, 1'b1, 128'h8, 32'h1);
    beat("u128sh4", 128'h0, 128'h8, 3'd4, 1'b0, 1'b0, 128'h8, 32'h0);
`ifdef NARROW_ROUND_EN
    beat("x18_xff", 128'hF8, 128'hF1, 3'd4, 1'b0, 1'b0, 128'hF2, 32'h2);
`else
    beat("x18_xff", 128'hF8, 128'hF1, 3'd4, 1'b0, 1'b0, 128'hF1, 32'h0);
`endif
    beat("m1_uns", 128'hF, 128'hF, 3'd0, 1'b1, 1'b0, 128'h0, 32'h1);
    beat("sh7", 128'h0, 128'h90000000000000000000000000000007, 3'd7, 1'b1, 1'b1,
         128'h90000000000000000000000000000007, 32'h0);
    out_ready = 1'b0;
    drive(128'h1, 128'h0, 3'd0, 1'b0, 1'b0);
    tick();
    chk("stall_ready1", in_ready, 1);
    drive(128'h2, 128'h0, 3'd0, 1'b0, 1'b0);
    tick();
    chk("stall_ready0", in_ready, 0);
    chk("stall_dst_a", out_dst, 128'h1);
    drive(128'h3, 128'h0, 3'd0, 1'b0, 1'b0);
    tick();
    chk("stall_hold_ready", in_ready, 0);
    chk("stall_hold_valid", out_valid, 1);
    chk("stall_hold_dst", out_dst, 128'h1);
    out_ready = 1'b1;
    #1;
    chk("release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int k = 2; k <= 3; k++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_dst", out_dst, 128'(k));
      tick();
    end
    chk("drain_empty", out_valid, 0);
    chk("drain_cnt", sat_cnt, exp_cnt);
    out_ready = 1'b0;
    drive(128'h0, 128'h8, 3'd0, 1'b1, 1'b1);
    tick();
    tick();
    in_valid = 1'b0;
    chk("flight_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_dst", out_dst, 0);
    chk("arst_sat", out_sat, 0);
    chk("arst_cnt", sat_cnt, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_cnt = '0;
    tick();
    beat("pre_clr", 128'h0, 128'h8, 3'd0, 1'b1, 1'b1, 128'h8, 32'h1);
    drive(128'h0, 128'h8, 3'd0, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("clr_valid", out_valid, 1);
    chk("clr_sat", out_sat, 32'h1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_cnt", sat_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
